// File: rtl/sparc_cu_pkg.sv
// Shared encodings for the SPARC-subset fetch/decode slice: ALU op codes,
// control-vector bit positions and the op/op2/op3 opcode constants.
package sparc_cu_pkg;

  localparam int VEC_W = 20;
  typedef logic [VEC_W-1:0] cu_vec_t;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_AND   = 4'b0001;
  localparam logic [3:0] ALU_OR    = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0100;
  localparam logic [3:0] ALU_ANDN  = 4'b0101;
  localparam logic [3:0] ALU_ORN   = 4'b0110;
  localparam logic [3:0] ALU_XNOR  = 4'b0111;
  localparam logic [3:0] ALU_ADDX  = 4'b1000;
  localparam logic [3:0] ALU_SUBX  = 4'b1001;
  localparam logic [3:0] ALU_SLL   = 4'b1010;
  localparam logic [3:0] ALU_SRL   = 4'b1011;
  localparam logic [3:0] ALU_SRA   = 4'b1100;
  localparam logic [3:0] ALU_PASSB = 4'b1101;

  localparam int B_JMPL     = 0;
  localparam int B_CALL     = 1;
  localparam int B_LOAD     = 2;
  localparam int B_RF_WE    = 3;
  localparam int B_MEM_SE   = 4;
  localparam int B_MEM_RW   = 5;
  localparam int B_MEM_EN   = 6;
  localparam int B_SIZE_LSB = 7;
  localparam int B_CC_EN    = 9;
  localparam int B_I31      = 10;
  localparam int B_I30      = 11;
  localparam int B_I24      = 12;
  localparam int B_I13      = 13;
  localparam int B_ALU_LSB  = 14;
  localparam int B_SETHI    = 18;
  localparam int B_BRANCH   = 19;

  localparam logic [1:0] OP_FMT2 = 2'b00;
  localparam logic [1:0] OP_CALL = 2'b01;
  localparam logic [1:0] OP_ARTH = 2'b10;
  localparam logic [1:0] OP_MEM  = 2'b11;

  localparam logic [2:0] OP2_BICC  = 3'b010;
  localparam logic [2:0] OP2_SETHI = 3'b100;

  localparam logic [5:0] OP3_JMPL = 6'b111000;
  localparam logic [5:0] OP3_SLL  = 6'b100101;
  localparam logic [5:0] OP3_SRL  = 6'b100110;
  localparam logic [5:0] OP3_SRA  = 6'b100111;

  // Memory access size: op3[1:0] ordering differs from the vector's size code.
  function automatic logic [1:0] mem_size(input logic [1:0] f);
    case (f)
      2'b00:   mem_size = 2'b10;
      2'b01:   mem_size = 2'b00;
      2'b10:   mem_size = 2'b01;
      default: mem_size = 2'b11;
    endcase
  endfunction

  // Returns {valid, alu_op} for the op3[5]==0 arithmetic/logic group.
  function automatic logic [4:0] arith_alu(input logic [3:0] f);
    case (f)
      4'b0000: arith_alu = {1'b1, ALU_ADD};
      4'b0001: arith_alu = {1'b1, ALU_AND};
      4'b0010: arith_alu = {1'b1, ALU_OR};
      4'b0011: arith_alu = {1'b1, ALU_XOR};
      4'b0100: arith_alu = {1'b1, ALU_SUB};
      4'b0101: arith_alu = {1'b1, ALU_ANDN};
      4'b0110: arith_alu = {1'b1, ALU_ORN};
      4'b0111: arith_alu = {1'b1, ALU_XNOR};
      4'b1000: arith_alu = {1'b1, ALU_ADDX};
      4'b1100: arith_alu = {1'b1, ALU_SUBX};
      default: arith_alu = {1'b0, ALU_ADD};
    endcase
  endfunction

endpackage

// File: rtl/pc_control_unit_if.sv
// Fetch/decode bundle: load enable and decode-stage instruction in,
// PC pair and decoded control vector out.
interface pc_control_unit_if;
  logic                  LE;
  logic [31:0]           instr;
  logic [31:0]           PC;
  logic [31:0]           nPC;
  logic [31:0]           nPC4;
  sparc_cu_pkg::cu_vec_t instr_signals;

  modport master (output LE, output instr,
                  input PC, input nPC, input nPC4, input instr_signals);
  modport slave  (input LE, input instr,
                  output PC, output nPC, output nPC4, output instr_signals);
endinterface

// File: rtl/control_unit.sv
// Combinational SPARC-subset decoder producing the ID-stage control vector.
module control_unit
  import sparc_cu_pkg::*;
(
  input  logic [31:0] instr,
  output cu_vec_t     instr_signals
);

  logic [1:0] op;
  logic [2:0] op2;
  logic [5:0] op3;
  logic [4:0] rd;
  logic [4:0] arith;

  assign op    = instr[31:30];
  assign op2   = instr[24:22];
  assign op3   = instr[24:19];
  assign rd    = instr[29:25];
  assign arith = arith_alu(op3[3:0]);

  always_comb begin
    instr_signals = '0;
    // An all-zero word is a pipeline bubble and must not leak field bits.
    if (instr != 32'd0) begin
      instr_signals[B_I31] = instr[31];
      instr_signals[B_I30] = instr[30];
      instr_signals[B_I24] = instr[24];
      instr_signals[B_I13] = instr[13];
      case (op)
        OP_CALL: begin
          instr_signals[B_CALL]  = 1'b1;
          instr_signals[B_RF_WE] = 1'b1;
          instr_signals[B_ALU_LSB +: 4] = ALU_ADD;
        end
        OP_FMT2: begin
          if (op2 == OP2_BICC) begin
            instr_signals[B_BRANCH] = 1'b1;
          end else if (op2 == OP2_SETHI) begin
            instr_signals[B_SETHI] = 1'b1;
            instr_signals[B_RF_WE] = (rd != 5'd0);
            instr_signals[B_ALU_LSB +: 4] = ALU_PASSB;
          end
        end
        OP_ARTH: begin
          if (op3 == OP3_JMPL) begin
            instr_signals[B_JMPL]  = 1'b1;
            instr_signals[B_RF_WE] = 1'b1;
            instr_signals[B_ALU_LSB +: 4] = ALU_ADD;
          end else if (!op3[5] && arith[4]) begin
            instr_signals[B_RF_WE] = 1'b1;
            instr_signals[B_CC_EN] = op3[4];
            instr_signals[B_ALU_LSB +: 4] = arith[3:0];
          end else if (op3 == OP3_SLL || op3 == OP3_SRL || op3 == OP3_SRA) begin
            instr_signals[B_RF_WE] = 1'b1;
            instr_signals[B_ALU_LSB +: 4] = (op3 == OP3_SLL) ? ALU_SLL :
                                            (op3 == OP3_SRL) ? ALU_SRL : ALU_SRA;
          end
        end
        default: begin
          instr_signals[B_MEM_EN] = 1'b1;
          instr_signals[B_MEM_RW] = op3[2];
          instr_signals[B_LOAD]   = ~op3[2];
          instr_signals[B_RF_WE]  = ~op3[2];
          instr_signals[B_MEM_SE] = op3[3];
          instr_signals[B_SIZE_LSB +: 2] = mem_size(op3[1:0]);
          instr_signals[B_ALU_LSB +: 4]  = ALU_ADD;
        end
      endcase
    end
  end

endmodule

// File: rtl/pc_control_unit.sv
// PC/nPC register pair with +4 incrementer feeding instruction fetch,
// plus the decode-stage control unit.
module pc_control_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] RESET_NPC = 32'd4
) (
  input logic              clk,
  input logic              clr,
  pc_control_unit_if.slave bus
);

  logic [31:0] pc_reg;
  logic [31:0] npc_reg;
  logic [31:0] npc4;

  // Wraps modulo 2^32 by construction.
  assign npc4 = npc_reg + 32'd4;

  always_ff @(posedge clk) begin
    if (clr) begin
      pc_reg  <= RESET_PC;
      npc_reg <= RESET_NPC;
    end else if (bus.LE) begin
      pc_reg  <= npc_reg;
      npc_reg <= npc4;
    end
  end

  assign bus.PC   = pc_reg;
  assign bus.nPC  = npc_reg;
  assign bus.nPC4 = npc4;

  control_unit u_control_unit (
    .instr         (bus.instr),
    .instr_signals (bus.instr_signals)
  );

endmodule

// File: tb/tb_pc_control_unit.sv
// Directed bench for pc_control_unit: PC/nPC sequencing, reset priority,
// nPC4 wraparound (second instance near the top of the address space) and decode vectors.
module tb_pc_control_unit;

  logic clk;
  logic clr;
  int   checks;
  int   failures;

  pc_control_unit_if bus ();
  pc_control_unit_if bus_w ();

  pc_control_unit dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  pc_control_unit #(
    .RESET_PC  (32'hFFFF_FFF8),
    .RESET_NPC (32'hFFFF_FFFC)
  ) dut_wrap (
    .clk (clk),
    .clr (clr),
    .bus (bus_w.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_pc(input string name, input logic [31:0] pc_exp,
                          input logic [31:0] npc_exp, input logic [31:0] npc4_exp);
    checks++;
    if (bus.PC !== pc_exp || bus.nPC !== npc_exp || bus.nPC4 !== npc4_exp) begin
      failures++;
      $display("FAIL %s: PC=%h nPC=%h nPC4=%h, expected PC=%h nPC=%h nPC4=%h",
               name, bus.PC, bus.nPC, bus.nPC4, pc_exp, npc_exp, npc4_exp);
    end else begin
      $display("ok   %s: PC=%h nPC=%h nPC4=%h", name, bus.PC, bus.nPC, bus.nPC4);
    end
  endtask

  task automatic test_reset;
    clr = 1'b1;
    bus.LE = 1'b1;
    bus_w.LE = 1'b1;
    bus.instr = 32'd0;
    bus_w.instr = 32'd0;
    tick();
    check_pc("reset", 32'd0, 32'd4, 32'd8);
    clr = 1'b0;
  endtask

  task automatic test_increment;
    bus.LE = 1'b1;
    bus_w.LE = 1'b0;
    tick();
    check_pc("inc1", 32'd4, 32'd8, 32'd12);
    tick();
    check_pc("inc2", 32'd8, 32'd12, 32'd16);
    tick();
    check_pc("inc3", 32'd12, 32'd16, 32'd20);
  endtask

  task automatic test_hold;
    bus.LE = 1'b0;
    tick();
    check_pc("hold1", 32'd12, 32'd16, 32'd20);
    tick();
    check_pc("hold2", 32'd12, 32'd16, 32'd20);
  endtask

  task automatic test_clr_priority;
    bus.LE = 1'b1;
    clr = 1'b1;
    bus.instr = 32'h8600_4002;
    #1;
    checks++;
    if (bus.instr_signals !== 20'h00408) begin
      failures++;
      $display("FAIL decode_during_clr: got %h expected %h", bus.instr_signals, 20'h00408);
    end else begin
      $display("ok   decode_during_clr: %h", bus.instr_signals);
    end
    tick();
    check_pc("clr_beats_le", 32'd0, 32'd4, 32'd8);
    clr = 1'b0;
    tick();
    check_pc("after_clr", 32'd4, 32'd8, 32'd12);
  endtask

  task automatic test_wrap;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bus_w.LE = 1'b0;
    checks++;
    if (bus_w.nPC !== 32'hFFFF_FFFC || bus_w.nPC4 !== 32'h0000_0000) begin
      failures++;
      $display("FAIL wrap_reset: nPC=%h nPC4=%h expected nPC=fffffffc nPC4=00000000",
               bus_w.nPC, bus_w.nPC4);
    end else begin
      $display("ok   wrap_reset: nPC=%h nPC4=%h", bus_w.nPC, bus_w.nPC4);
    end
    bus_w.LE = 1'b1;
    tick();
    bus_w.LE = 1'b0;
    checks++;
    if (bus_w.PC !== 32'hFFFF_FFFC || bus_w.nPC !== 32'h0 || bus_w.nPC4 !== 32'h4) begin
      failures++;
      $display("FAIL wrap_step: PC=%h nPC=%h nPC4=%h expected fffffffc 00000000 00000004",
               bus_w.PC, bus_w.nPC, bus_w.nPC4);
    end else begin
      $display("ok   wrap_step: PC=%h nPC=%h nPC4=%h", bus_w.PC, bus_w.nPC, bus_w.nPC4);
    end
  endtask

  task automatic test_decode;
    logic [31:0] vin [14];
    logic [19:0] vexp [14];
    vin[0]  = 32'h8600_4002; vexp[0]  = 20'h00408;  // add r1,r2,r3
    vin[1]  = 32'hC400_6004; vexp[1]  = 20'h02D4C;  // ld [r1+4],r2
    vin[2]  = 32'h1080_0004; vexp[2]  = 20'h80000;  // ba
    vin[3]  = 32'h4000_0010; vexp[3]  = 20'h0080A;  // call
    vin[4]  = 32'h0000_0000; vexp[4]  = 20'h00000;  // bubble
    vin[5]  = 32'h0300_0010; vexp[5]  = 20'h75008;  // sethi r1
    vin[6]  = 32'h0100_0000; vexp[6]  = 20'h75000;  // sethi r0: no write
    vin[7]  = 32'hC420_6004; vexp[7]  = 20'h02D60;  // st word
    vin[8]  = 32'hC450_6004; vexp[8]  = 20'h02CDC;  // ldsh
    vin[9]  = 32'h86A0_4002; vexp[9]  = 20'h10608;  // subcc
    vin[10] = 32'h81C0_6008; vexp[10] = 20'h03409;  // jmpl
    vin[11] = 32'h8728_6003; vexp[11] = 20'h2B408;  // sll imm
    vin[12] = 32'h8648_4002; vexp[12] = 20'h00400;  // unlisted op3
    vin[13] = 32'h0000_2000; vexp[13] = 20'h02000;  // other op2: field bits only
    for (int i = 0; i < 14; i++) begin
      bus.instr = vin[i];
      #1;
      checks++;
      if (bus.instr_signals !== vexp[i]) begin
        failures++;
        $display("FAIL decode[%0d] instr=%h: got %h expected %h",
                 i, vin[i], bus.instr_signals, vexp[i]);
      end else begin
        $display("ok   decode[%0d] instr=%h: %h", i, vin[i], bus.instr_signals);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clr = 1'b0;
    bus.LE = 1'b0;
    bus.instr = 32'd0;
    bus_w.LE = 1'b0;
    bus_w.instr = 32'd0;
    test_reset();
    test_increment();
    test_hold();
    test_clr_priority();
    test_wrap();
    test_decode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
